trng_word_packer: RTL



---
 rtl/trng_pkg.sv | 7 +
 rtl/trng_word_packer_if.sv | 14 +
 rtl/trng_sync_fifo.sv | 48 ++++
 rtl/trng_word_packer.sv | 83 ++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: default word width, FIFO depth, RCT cutoff and FIFO level width shared by the TRNG packer files
package trng_pkg;
   localparam int TRNG_WORD_W     = 32;
   localparam int TRNG_FIFO_DEPTH = 4;
   localparam int TRNG_RCT_CUTOFF = 32;
   localparam int TRNG_LVL_W      = $clog2(TRNG_FIFO_DEPTH) + 1;
endpackage

// File: rtl/trng_word_packer_if.sv
// trng_word_packer_if: raw bit stream (bit_in/bit_vld) in, packed word handshake (word_out/word_vld/word_rdy) out; master = source/consumer side, slave = packer
interface trng_word_packer_if
   import trng_pkg::*;
#(
   parameter int WORD_W = TRNG_WORD_W
);
   logic              bit_in;
   logic              bit_vld;
   logic              word_rdy;
   logic              word_vld;
   logic [WORD_W-1:0] word_out;
   modport master (output bit_in, bit_vld, word_rdy, input word_out, word_vld);
   modport slave  (input bit_in, bit_vld, word_rdy, output word_out, word_vld);
endinterface

// File: rtl/trng_sync_fifo.sv
// trng_sync_fifo: single-clock show-ahead FIFO; push/push_data/full in, pop/pop_data/empty out, level = words held; pop-then-push allowed when full
module trng_sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   output logic          full,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          empty,
   output logic [LW-1:0] level
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          do_push, do_pop;
   assign full     = lvl_q == LW'(DEPTH);
   assign empty    = lvl_q == '0;
   assign pop_data = mem_q[rd_q];
   assign level    = lvl_q;
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = push_data;
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
endmodule

// File: rtl/trng_word_packer.sv
// trng_word_packer: von Neumann corrector + repetition-count test + LSB-first word packing into a FIFO; clk/rst/enable/vn_en/clr in, bus (bit stream in, word handshake out), fifo_level/ovf/rct_fail out
module trng_word_packer
   import trng_pkg::*;
#(
   parameter int WORD_W     = TRNG_WORD_W,
   parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
   parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              vn_en,
   input  logic              clr,
   trng_word_packer_if.slave bus,
   output logic [LW-1:0]     fifo_level,
   output logic              ovf,
   output logic              rct_fail
);
   localparam int CW = $clog2(WORD_W);
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
   localparam logic [RW-1:0] CUT  = RW'(RCT_CUTOFF);
   logic              pair_vld_q, pair_vld_d, pair_bit_q, pair_bit_d;
   logic [WORD_W-1:0] word_q, word_d, push_data, word_out;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]     run_q, run_d;
   logic              last_q, last_d, ovf_q, ovf_d, rct_q, rct_d;
   logic              take, emit, ebit, push, pop, full, empty;
   always_comb begin
      take       = enable & bus.bit_vld;
      emit       = vn_en ? take & pair_vld_q & (pair_bit_q != bus.bit_in) : take;
      ebit       = vn_en ? pair_bit_q : bus.bit_in;
      pair_vld_d = enable & vn_en & (take ? ~pair_vld_q : pair_vld_q);
      pair_bit_d = take & ~pair_vld_q ? bus.bit_in : pair_bit_q;
      push_data  = word_q;
      push_data[cnt_q] = ebit;
      push       = emit & (cnt_q == LAST);
      word_d     = !enable || push ? '0 : emit ? push_data : word_q;
      cnt_d      = !enable || push ? '0 : emit ? cnt_q + 1'b1 : cnt_q;
      run_d      = !enable ? '0 : !take ? run_q :
                   (run_q != '0 && bus.bit_in == last_q) ? (run_q == CUT ? CUT : run_q + 1'b1) : RW'(1);
      last_d     = take ? bus.bit_in : last_q;
      pop        = ~empty & bus.word_rdy;
      ovf_d      = (push & full & ~pop) | (ovf_q & ~clr);
      rct_d      = (take & (run_d == CUT)) | (rct_q & ~clr);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pair_vld_q <= 1'b0;
         pair_bit_q <= 1'b0;
         word_q     <= '0;
         cnt_q      <= '0;
         run_q      <= '0;
         last_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rct_q      <= 1'b0;
      end else begin
         pair_vld_q <= pair_vld_d;
         pair_bit_q <= pair_bit_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         rct_q      <= rct_d;
      end
   trng_sync_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_data),
      .full     (full),
      .pop      (pop),
      .pop_data (word_out),
      .empty    (empty),
      .level    (fifo_level)
   );
   assign bus.word_out = word_out;
   assign bus.word_vld = ~empty;
   assign ovf          = ovf_q;
   assign rct_fail     = rct_q;
endmodule
